// File: rtl/mig_ui_arbiter_pkg.sv
// Shared constants and types for the two-port MIG UI arbiter.
package mig_ui_arbiter_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;
    localparam int MASK_W_DEF = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/mig_ui_arbiter_tag.sv
// Outstanding-read tag FIFO: remembers which port issued each read so that
// in-order read data can be routed back. Pointers carry one extra wrap bit.
module mig_tag_fifo
    import mig_ui_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic push_data_i,
    input  logic pop_i,
    output logic pop_data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] mem_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop against an empty FIFO that is being pushed this cycle takes the
    // new tag straight through and leaves the FIFO empty.
    assign do_push    = push_i && (!full_o || pop_i) && !(empty_o && pop_i);
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = empty_o ? push_data_i : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers, flushed by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Tag storage; contents are meaningless outside the pointer window.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/mig_ui_arbiter.sv
// Round-robin arbiter sharing one MIG UI port between two masters.
// Read data is routed back to its issuer through an in-order tag FIFO.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no transaction; pick a requester when calibrated
// ST_ISSUE | drive command/write data of the latched grant until both done
module mig_ui_arbiter
    import mig_ui_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int MASK_WIDTH = MASK_W_DEF,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_write,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    input  logic [MASK_WIDTH-1:0] p0_req_mask,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_data,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_write,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    input  logic [MASK_WIDTH-1:0] p1_req_mask,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_data,

    input  logic                  calib_done,

    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [ADDR_WIDTH-1:0] app_addr,
    input  logic                  app_rdy,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [DATA_WIDTH-1:0] app_wdf_data,
    output logic [MASK_WIDTH-1:0] app_wdf_mask,
    input  logic                  app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0] app_rd_data,
    input  logic                  app_rd_data_valid,

    output logic                  err_underflow
);

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  cmd_done_q, cmd_done_d;
    logic                  data_done_q, data_done_d;
    logic [1:0]            rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  err_q;

    logic                  elig0, elig1, pick;
    logic                  g_write;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [MASK_WIDTH-1:0] g_mask;
    logic                  cmd_hs;
    logic                  tag_push, tag_out, tag_full, tag_empty;
    logic                  underflow;

    // Reads wait while every tag slot is in use; writes never need a tag.
    assign elig0 = p0_req_valid && (p0_req_write || !tag_full);
    assign elig1 = p1_req_valid && (p1_req_write || !tag_full);
    assign pick  = (elig0 && elig1) ? !last_grant_q : elig1;

    // Request fields are held stable by the master, so muxing them by the
    // latched grant keeps app_* independent of the valid inputs.
    assign g_write = grant_q ? p1_req_write : p0_req_write;
    assign g_addr  = grant_q ? p1_req_addr  : p0_req_addr;
    assign g_wdata = grant_q ? p1_req_wdata : p0_req_wdata;
    assign g_mask  = grant_q ? p1_req_mask  : p0_req_mask;

    // Grant selection, handshake tracking and app_* drive.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cmd_done_d   = cmd_done_q;
        data_done_d  = data_done_q;
        app_en       = 1'b0;
        app_cmd      = CMD_WRITE;
        app_addr     = '0;
        app_wdf_wren = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        cmd_hs       = 1'b0;
        p0_req_ready = 1'b0;
        p1_req_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (calib_done && (elig0 || elig1)) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    cmd_done_d   = 1'b0;
                    data_done_d  = 1'b0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                app_en   = !cmd_done_q;
                app_cmd  = g_write ? CMD_WRITE : CMD_READ;
                app_addr = g_addr;
                if (g_write) begin
                    app_wdf_wren = !data_done_q;
                    app_wdf_data = g_wdata;
                    app_wdf_mask = g_mask;
                end
                cmd_hs      = app_en && app_rdy;
                cmd_done_d  = cmd_done_q || cmd_hs;
                data_done_d = data_done_q || !g_write || (app_wdf_wren && app_wdf_rdy);
                if (cmd_done_d && data_done_d) begin
                    p0_req_ready = !grant_q;
                    p1_req_ready = grant_q;
                    state_d      = ST_IDLE;
                end
            end
        endcase
    end

    assign app_wdf_end = app_wdf_wren;

    // FSM and grant registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cmd_done_q   <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cmd_done_q   <= cmd_done_d;
            data_done_q  <= data_done_d;
        end
    end

    assign tag_push  = cmd_hs && !g_write;
    assign underflow = app_rd_data_valid && tag_empty && !tag_push;

    mig_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (tag_push),
        .push_data_i (grant_q),
        .pop_i       (app_rd_data_valid),
        .pop_data_o  (tag_out),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    // Register returning read data and steer the valid to the tagged port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 2'b00;
            if (app_rd_data_valid && !underflow) begin
                rsp_data_q  <= app_rd_data;
                rsp_valid_q <= tag_out ? 2'b10 : 2'b01;
            end
            if (underflow) err_q <= 1'b1;
        end
    end

    assign p0_rsp_valid  = rsp_valid_q[0];
    assign p1_rsp_valid  = rsp_valid_q[1];
    assign p0_rsp_data   = rsp_data_q;
    assign p1_rsp_data   = rsp_data_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_mig_ui_arbiter.sv
// Bench for mig_ui_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level model of round-robin and read routing.
module tb_mig_ui_arbiter;

    localparam int NR = 40;

    logic         clk = 1'b0;
    logic         reset;
    logic         p0_req_valid, p0_req_ready, p0_req_write, p0_rsp_valid;
    logic [27:0]  p0_req_addr;
    logic [127:0] p0_req_wdata, p0_rsp_data;
    logic [15:0]  p0_req_mask;
    logic         p1_req_valid, p1_req_ready, p1_req_write, p1_rsp_valid;
    logic [27:0]  p1_req_addr;
    logic [127:0] p1_req_wdata, p1_rsp_data;
    logic [15:0]  p1_req_mask;
    logic         calib_done;
    logic         app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [2:0]   app_cmd;
    logic [27:0]  app_addr;
    logic [127:0] app_wdf_data, app_rd_data;
    logic [15:0]  app_wdf_mask;
    logic         app_rd_data_valid;
    logic         err_underflow;

    int n_chk = 0;
    int n_bad = 0;

    mig_ui_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_mask(p0_req_mask),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_mask(p1_req_mask),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
        .calib_done(calib_done),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input int port, input int maxc, output int n);
        n = -1;
        for (int i = 0; i < maxc; i++) begin
            smp();
            if ((port == 0 && p0_req_ready) || (port == 1 && p1_req_ready)) begin
                n = i;
                break;
            end
            if (i < maxc - 1) step();
        end
    endtask

    // Return one beat of read data and check where it lands a cycle later.
    task automatic ret_read(input string tag, input logic [127:0] d, input logic [1:0] exp_rv);
        app_rd_data_valid = 1'b1;
        app_rd_data       = d;
        step();
        app_rd_data_valid = 1'b0;
        smp();
        chk(tag, 128'({p1_rsp_valid, p0_rsp_valid}), 128'(exp_rv));
        if (exp_rv[0]) chk({tag, "_d0"}, p0_rsp_data, d);
        if (exp_rv[1]) chk({tag, "_d1"}, p1_rsp_data, d);
        step();
    endtask

    // Randomized-run stimulus tables and model state.
    logic         it_w [2][NR+1];
    logic [27:0]  it_a [2][NR+1];
    logic [127:0] it_d [2][NR+1];
    logic [15:0]  it_m [2][NR+1];
    int           idx [2];
    bit           mq [$];
    bit           m_last, m_port, m_busy, m_cmd, m_dat, drv_port;
    logic [1:0]   exp_rv, rdy;
    logic [127:0] exp_rd;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unsigned r;
        reset = 1'b1;
        calib_done = 1'b0;
        p0_req_valid = 1'b0; p0_req_write = 1'b0; p0_req_addr = '0; p0_req_wdata = '0; p0_req_mask = '0;
        p1_req_valid = 1'b0; p1_req_write = 1'b0; p1_req_addr = '0; p1_req_wdata = '0; p1_req_mask = '0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
        step();
        do_reset();

        // Reset state.
        smp();
        chk("rst_en", 128'(app_en), 128'(0));
        chk("rst_wren", 128'({app_wdf_wren, app_wdf_end}), 128'(0));
        chk("rst_ready", 128'({p1_req_ready, p0_req_ready}), 128'(0));
        chk("rst_rsp", 128'({p1_rsp_valid, p0_rsp_valid}), 128'(0));
        chk("rst_err", 128'(err_underflow), 128'(0));
        step();

        // Requests pending before calibration; p0 must win the first tie.
        p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 28'h0000200;
        p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = 28'h0000300;
        app_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("calib_en", 128'(app_en), 128'(0));
            chk("calib_rdy", 128'({p1_req_ready, p0_req_ready}), 128'(0));
            step();
        end
        calib_done = 1'b1;
        smp();
        chk("calib_idle_en", 128'(app_en), 128'(0));
        step();
        smp();
        chk("calib_first_rdy", 128'({p1_req_ready, p0_req_ready}), 128'(2'b01));
        chk("calib_first_addr", 128'(app_addr), 128'(28'h0000200));
        step();
        p0_req_valid = 1'b0;
        step();
        smp();
        chk("calib_second_rdy", 128'({p1_req_ready, p0_req_ready}), 128'(2'b10));
        chk("calib_second_addr", 128'(app_addr), 128'(28'h0000300));
        step();
        p1_req_valid = 1'b0;
        ret_read("calib_rsp0", 128'hA, 2'b01);
        ret_read("calib_rsp1", 128'hB, 2'b10);

        // p0 read with immediate app_rdy.
        p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 28'h0000040;
        smp();
        chk("rd_idle_en", 128'(app_en), 128'(0));
        step();
        smp();
        chk("rd_en", 128'(app_en), 128'(1));
        chk("rd_cmd", 128'(app_cmd), 128'(3'b001));
        chk("rd_addr", 128'(app_addr), 128'(28'h0000040));
        chk("rd_ready", 128'({p1_req_ready, p0_req_ready}), 128'(2'b01));
        step();
        p0_req_valid = 1'b0;
        smp();
        chk("rd_en_drop", 128'(app_en), 128'(0));
        step();
        app_rd_data_valid = 1'b1;
        app_rd_data = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
        smp();
        chk("rd_rsp_early", 128'({p1_rsp_valid, p0_rsp_valid}), 128'(0));
        step();
        app_rd_data_valid = 1'b0;
        smp();
        chk("rd_rsp", 128'({p1_rsp_valid, p0_rsp_valid}), 128'(2'b01));
        chk("rd_rsp_data", p0_rsp_data, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
        step();
        smp();
        chk("rd_rsp_single", 128'({p1_rsp_valid, p0_rsp_valid}), 128'(0));
        step();

        // p1 write with write-data accept lagging the command accept.
        p1_req_valid = 1'b1; p1_req_write = 1'b1; p1_req_addr = 28'h0000080;
        p1_req_wdata = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        p1_req_mask = 16'h00F0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b0;
        step();
        smp();
        chk("wr_en", 128'(app_en), 128'(1));
        chk("wr_cmd", 128'(app_cmd), 128'(3'b000));
        chk("wr_wren", 128'({app_wdf_wren, app_wdf_end}), 128'(2'b11));
        chk("wr_ready_cmd", 128'({p1_req_ready, p0_req_ready}), 128'(0));
        step();
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("wr_hold_en", 128'(app_en), 128'(0));
            chk("wr_hold_wren", 128'(app_wdf_wren), 128'(1));
            chk("wr_hold_ready", 128'({p1_req_ready, p0_req_ready}), 128'(0));
            step();
        end
        app_wdf_rdy = 1'b1;
        smp();
        chk("wr_data", app_wdf_data, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
        chk("wr_mask", 128'(app_wdf_mask), 128'(16'h00F0));
        chk("wr_ready", 128'({p1_req_ready, p0_req_ready}), 128'(2'b10));
        step();
        p1_req_valid = 1'b0;
        app_wdf_rdy = 1'b0;
        smp();
        chk("wr_wren_drop", 128'(app_wdf_wren), 128'(0));
        step();

        // Tag FIFO full: four reads accepted, the fifth waits for read data.
        p0_req_valid = 1'b1; p0_req_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            p0_req_addr = 28'(28'h100 + 16 * k);
            wait_ready(0, 6, n);
            chk("full_acc", 128'(n >= 0), 128'(1));
            step();
        end
        p0_req_addr = 28'h0000140;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("full_hold_en", 128'(app_en), 128'(0));
            chk("full_hold_rdy", 128'(p0_req_ready), 128'(0));
            step();
        end
        app_rd_data_valid = 1'b1;
        app_rd_data = 128'h55;
        step();
        app_rd_data_valid = 1'b0;
        wait_ready(0, 4, n);
        chk("full_fifth", 128'(n >= 0), 128'(1));
        if (n >= 0) chk("full_fifth_addr", 128'(app_addr), 128'(28'h0000140));
        step();
        p0_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) ret_read("full_drain", 128'(100 + k), 2'b01);

        // Read data with nothing outstanding.
        ret_read("unf_rsp", 128'hBAD, 2'b00);
        smp();
        chk("unf_err", 128'(err_underflow), 128'(1));
        step();

        // Reset while a write is stuck in ISSUE.
        p0_req_valid = 1'b1; p0_req_write = 1'b1; p0_req_addr = 28'h0000700;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        step();
        smp();
        chk("midrst_issue_en", 128'(app_en), 128'(1));
        step();
        reset = 1'b1;
        p0_req_valid = 1'b0;
        step();
        smp();
        chk("midrst_en", 128'(app_en), 128'(0));
        chk("midrst_wren", 128'(app_wdf_wren), 128'(0));
        chk("midrst_err", 128'(err_underflow), 128'(0));
        chk("midrst_rsp", 128'({p1_rsp_valid, p0_rsp_valid}), 128'(0));
        chk("midrst_addr", 128'(app_addr), 128'(0));
        step();
        reset = 1'b0;
        app_rdy = 1'b1;
        p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 28'h0000500;
        p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = 28'h0000600;
        step();
        smp();
        chk("post_rst_first", 128'({p1_req_ready, p0_req_ready}), 128'(2'b01));
        step();
        p0_req_valid = 1'b0;
        step();
        smp();
        chk("post_rst_second", 128'({p1_req_ready, p0_req_ready}), 128'(2'b10));
        step();
        p1_req_valid = 1'b0;
        ret_read("post_rst_rsp0", 128'hC0, 2'b01);
        ret_read("post_rst_rsp1", 128'hC1, 2'b10);

        // Randomized run against the transaction model.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i <= NR; i++) begin
                r = $urandom;
                it_w[p][i] = (i < NR) ? 1'($urandom_range(0, 1)) : 1'b0;
                it_a[p][i] = {r[23:0], 4'h0};
                it_d[p][i] = {$urandom, $urandom, $urandom, $urandom};
                it_m[p][i] = r[31:16];
            end
        end
        do_reset();
        idx[0] = 0; idx[1] = 0;
        m_last = 1'b1; m_busy = 1'b0; m_cmd = 1'b0; m_dat = 1'b0; m_port = 1'b0;
        exp_rv = 2'b00; exp_rd = '0; drv_port = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (idx[0] >= NR && idx[1] >= NR && mq.size() == 0 && !m_busy && exp_rv == 2'b00) break;
            p0_req_valid = (idx[0] < NR);
            p0_req_write = it_w[0][idx[0]]; p0_req_addr = it_a[0][idx[0]];
            p0_req_wdata = it_d[0][idx[0]]; p0_req_mask = it_m[0][idx[0]];
            p1_req_valid = (idx[1] < NR);
            p1_req_write = it_w[1][idx[1]]; p1_req_addr = it_a[1][idx[1]];
            p1_req_wdata = it_d[1][idx[1]]; p1_req_mask = it_m[1][idx[1]];
            app_rdy     = ($urandom_range(0, 3) != 0);
            app_wdf_rdy = ($urandom_range(0, 3) != 0);
            if (mq.size() >= 2 || (mq.size() > 0 && $urandom_range(0, 2) == 0)) begin
                drv_port = mq.pop_front();
                app_rd_data_valid = 1'b1;
                app_rd_data = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                app_rd_data_valid = 1'b0;
            end
            smp();
            chk("rnd_rsp_v", 128'({p1_rsp_valid, p0_rsp_valid}), 128'(exp_rv));
            if (exp_rv != 2'b00)
                chk("rnd_rsp_d", exp_rv[0] ? p0_rsp_data : p1_rsp_data, exp_rd);
            exp_rv = app_rd_data_valid ? (drv_port ? 2'b10 : 2'b01) : 2'b00;
            exp_rd = app_rd_data;
            if (((app_en && app_rdy) || (app_wdf_wren && app_wdf_rdy)) && !m_busy) begin
                m_busy = 1'b1; m_cmd = 1'b0; m_dat = 1'b0;
                m_port = (p0_req_valid && p1_req_valid) ? !m_last : p1_req_valid;
                m_last = m_port;
            end
            if (app_en && app_rdy) begin
                chk("rnd_cmd_once", 128'(m_cmd), 128'(0));
                m_cmd = 1'b1;
                chk("rnd_addr", 128'(app_addr), 128'(it_a[m_port][idx[m_port]]));
                chk("rnd_cmd", 128'(app_cmd), 128'(it_w[m_port][idx[m_port]] ? 3'b000 : 3'b001));
                if (!it_w[m_port][idx[m_port]]) mq.push_back(m_port);
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                chk("rnd_dat_once", 128'(m_dat), 128'(0));
                m_dat = 1'b1;
                chk("rnd_wdata", app_wdf_data, it_d[m_port][idx[m_port]]);
                chk("rnd_wmask", 128'(app_wdf_mask), 128'(it_m[m_port][idx[m_port]]));
            end
            rdy = {p1_req_ready, p0_req_ready};
            if (rdy != 2'b00) begin
                chk("rnd_ready_port", 128'(rdy), 128'(m_busy ? (m_port ? 2'b10 : 2'b01) : 2'b00));
                chk("rnd_ready_hs", 128'({m_cmd, m_dat}), 128'({1'b1, it_w[m_port][idx[m_port]]}));
                if (rdy[1]) idx[1] = idx[1] + 1;
                else        idx[0] = idx[0] + 1;
                m_busy = 1'b0;
            end
            step();
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        app_rd_data_valid = 1'b0;
        chk("rnd_done0", 128'(idx[0]), 128'(NR));
        chk("rnd_done1", 128'(idx[1]), 128'(NR));
        chk("rnd_mq_empty", 128'(mq.size()), 128'(0));
        smp();
        chk("rnd_err", 128'(err_underflow), 128'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
